// File: rtl/trng_health_fifo_if.sv
// Handshake bundle between the TRNG core, the health-test FIFO and its consumer.
// Signal names are seen from the health-test block's side.
interface trng_health_fifo_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i_rnd_dat;
  logic             i_rnd_valid;
  logic             o_rnd_read;
  logic [WIDTH-1:0] o_dat;
  logic             o_valid;
  logic             i_read;
  logic             i_clear_alarm;
  logic             o_alarm;
  logic             o_rct_fail;
  logic             o_apt_fail;

  modport slave (
    input  i_rnd_dat, i_rnd_valid, i_read, i_clear_alarm,
    output o_rnd_read, o_dat, o_valid, o_alarm, o_rct_fail, o_apt_fail
  );

  modport master (
    output i_rnd_dat, i_rnd_valid, i_read, i_clear_alarm,
    input  o_rnd_read, o_dat, o_valid, o_alarm, o_rct_fail, o_apt_fail
  );
endinterface

// File: rtl/trng_health_fifo.sv
// Continuous health tests (repetition count + adaptive proportion) on TRNG words,
// startup discard, first-word-fall-through output FIFO and a sticky alarm.
module trng_health_fifo #(
  parameter int WIDTH         = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int STARTUP_WORDS = 4,
  parameter int RCT_CUTOFF    = 4,
  parameter int APT_WINDOW    = 16,
  parameter int APT_CUTOFF    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  trng_health_fifo_if.slave     bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW_W  = $clog2(STARTUP_WORDS) + 1;
  localparam int RCT_W = $clog2(RCT_CUTOFF) + 1;
  localparam int APT_W = $clog2(APT_CUTOFF) + 1;
  localparam int IDX_W = $clog2(APT_WINDOW);

  localparam logic [1:0] ST_STARTUP = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_ALARM   = 2'd2;

  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [SW_W-1:0]  SW_LAST   = SW_W'(STARTUP_WORDS - 1);
  localparam logic [RCT_W-1:0] RCT_MAX   = RCT_W'(RCT_CUTOFF);
  localparam logic [APT_W-1:0] APT_MAX   = APT_W'(APT_CUTOFF);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(APT_WINDOW - 1);

  logic [1:0]       state_q;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SW_W-1:0]  start_cnt_q;
  logic             have_last_q;
  logic [WIDTH-1:0] last_q;
  logic [RCT_W-1:0] rct_cnt_q, rct_cnt_d;
  logic [WIDTH-1:0] ref_q;
  logic [IDX_W-1:0] apt_idx_q;
  logic [APT_W-1:0] apt_cnt_q, apt_cnt_d;
  logic             alarm_q, rct_fail_q, apt_fail_q;

  logic fifo_full, fifo_empty, accept, rct_hit, apt_hit, fail;
  logic push, pop, out_valid, startup_done;
  logic [WIDTH-1:0] word;

  assign word       = bus.i_rnd_dat;
  assign fifo_full  = (cnt_q == FIFO_FULL);
  assign fifo_empty = (cnt_q == '0);
  assign accept     = bus.i_rnd_valid & ~i_reset & (state_q != ST_ALARM)
                    & ((state_q == ST_STARTUP) | ~fifo_full);

  always_comb begin
    rct_cnt_d = RCT_W'(1);
    if (have_last_q && word == last_q) begin
      rct_cnt_d = (rct_cnt_q == RCT_MAX) ? rct_cnt_q : rct_cnt_q + RCT_W'(1);
    end
  end

  always_comb begin
    apt_cnt_d = apt_cnt_q;
    if (apt_idx_q == '0) begin
      apt_cnt_d = APT_W'(1);
    end else if (word == ref_q && apt_cnt_q != APT_MAX) begin
      apt_cnt_d = apt_cnt_q + APT_W'(1);
    end
  end

  assign rct_hit      = accept & (rct_cnt_d == RCT_MAX);
  assign apt_hit      = accept & (apt_cnt_d == APT_MAX);
  assign fail         = rct_hit | apt_hit;
  // A failing word is never buffered; accept already guarantees room in RUN.
  assign push         = accept & (state_q == ST_RUN) & ~fail;
  assign out_valid    = ~fifo_empty & (state_q == ST_RUN);
  assign pop          = bus.i_read & out_valid;
  assign startup_done = accept & (state_q == ST_STARTUP) & ~fail & (start_cnt_q == SW_LAST);

  assign bus.o_rnd_read = accept;
  assign bus.o_valid    = out_valid;
  assign bus.o_dat      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.o_alarm    = alarm_q;
  assign bus.o_rct_fail = rct_fail_q;
  assign bus.o_apt_fail = apt_fail_q;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_STARTUP;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      start_cnt_q <= '0;
      have_last_q <= 1'b0;
      last_q      <= '0;
      rct_cnt_q   <= '0;
      ref_q       <= '0;
      apt_idx_q   <= '0;
      apt_cnt_q   <= '0;
      alarm_q     <= 1'b0;
      rct_fail_q  <= 1'b0;
      apt_fail_q  <= 1'b0;
    end else begin
      if (accept) begin
        have_last_q <= 1'b1;
        last_q      <= word;
        rct_cnt_q   <= rct_cnt_d;
        apt_cnt_q   <= apt_cnt_d;
        if (apt_idx_q == '0) begin
          ref_q <= word;
        end
        apt_idx_q <= (apt_idx_q == IDX_LAST) ? '0 : apt_idx_q + IDX_W'(1);
      end

      if (fail) begin
        state_q     <= ST_ALARM;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        cnt_q       <= '0;
        start_cnt_q <= '0;
        alarm_q     <= 1'b1;
        rct_fail_q  <= rct_fail_q | rct_hit;
        apt_fail_q  <= apt_fail_q | apt_hit;
      end else if (state_q == ST_ALARM) begin
        // Clearing restarts both tests from scratch along with the startup discard.
        if (bus.i_clear_alarm) begin
          state_q     <= ST_STARTUP;
          start_cnt_q <= '0;
          have_last_q <= 1'b0;
          rct_cnt_q   <= '0;
          apt_idx_q   <= '0;
          apt_cnt_q   <= '0;
          alarm_q     <= 1'b0;
          rct_fail_q  <= 1'b0;
          apt_fail_q  <= 1'b0;
        end
      end else begin
        if (startup_done) begin
          state_q <= ST_RUN;
        end
        if (accept && state_q == ST_STARTUP) begin
          start_cnt_q <= start_cnt_q + SW_W'(1);
        end
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + CNT_W'(1);
          2'b01:   cnt_q <= cnt_q - CNT_W'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

endmodule
